bank_htu_victim_ctrl: RTL and testbench
=======================================

# bank_htu_victim_ctrl

Replacement controller for one bank hit-test-unit set of 8 ways. Tracks per-way valid and refill-pending (lock) state, selects a victim way for each allocation request, and drives the access vector of the 8-way PLRU tree. It sits between the bank miss path, the refill return path and the PLRU tree instance.

## Interface

- No parameters; ways fixed at 8, way index 3 bits.
- clk_i  input  1  clock, all state updates on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- hit_vld_i  input  1  lookup hit this cycle.
- hit_way_i  input  8  one-hot hit way.
- alloc_req_i  input  1  miss needs a way; held high until grant.
- alloc_gnt_o  output  1  one-cycle grant pulse.
- alloc_way_o  output  8  one-hot granted way; meaningful only with alloc_gnt_o.
- alloc_evict_o  output  1  granted way held valid data; eviction required.
- refill_vld_i  input  1  refill complete.
- refill_way_i  input  3  way index of completed refill.
- inval_vld_i  input  1  invalidate request.
- inval_way_i  input  3  way index to invalidate.
- plru_access_o  output  8  access vector to the PLRU tree.
- plru_oldest_i  input  8  one-hot oldest way from the PLRU tree.
- way_valid_o  output  8  valid bits.
- way_lock_o  output  8  refill-pending bits.
- err_o  output  1  sticky protocol error.
- stall_cnt_o  output  16  saturating count of all-locked cycles.

## Operation

- State machine: IDLE, PICK, GNT.
  - IDLE: alloc_req_i=1 → PICK.
  - PICK: if every way is locked, stay in PICK and increment stall_cnt_o (saturates at 16'hFFFF). Otherwise register the victim and go to GNT.
  - GNT: drive alloc_gnt_o=1 and alloc_way_o from the victim register, then → IDLE.
- Victim priority, evaluated in PICK from the current registered state:
  - lowest-index way that is invalid and unlocked;
  - else plru_oldest_i, if that way is unlocked;
  - else the lowest-index unlocked way.
- alloc_evict_o = |(victim & way_valid_q), evaluated in the GNT cycle.
- At the end of GNT, for the victim way: lock is set and valid is cleared.
- refill_vld_i:
  - If the way is locked: clear lock, set valid.
  - If the way is not locked: ignore it and set err_o.
- inval_vld_i:
  - If the way is unlocked: clear valid.
  - If the way is locked: ignore it. This is not an error.
- Hits: the effective hit is hit_way_i & way_valid_q when hit_vld_i=1. A hit_way_i that is not one-hot sets err_o and is ignored.
- plru_access_o is combinational, the OR of:
  - the effective hit;
  - the one-hot of refill_way_i on an accepted refill;
  - alloc_way_o during GNT.
- Same-cycle events on the same way: lock/valid updates from GNT, refill and invalidate are applied in that order, so a later event overrides an earlier one.
- alloc_req_i dropping before grant: the FSM still completes to GNT. The requester ignores that grant, but the lock is still taken, so the requester must not drop the request.

## Timing

- Reset values:
  - state IDLE;
  - way_valid_o=0, way_lock_o=0;
  - alloc_gnt_o=0, alloc_way_o=0, alloc_evict_o=0;
  - err_o=0, stall_cnt_o=0;
  - plru_access_o=0, since its inputs are gated by state and the valid inputs.
- Latency: alloc_req_i first seen high in cycle N gives alloc_gnt_o in cycle N+2 when a way is free. Each all-locked cycle adds one cycle.
- Lock and valid changes are visible on way_lock_o and way_valid_o the cycle after the event.
- PICK uses registered state only. A refill in PICK cycle N frees its way for selection in cycle N+1.
- PLRU update: plru_oldest_i reflects plru_access_o of the previous cycle, so PICK sees hits from up to the prior cycle.
- Back-to-back requests: at most one grant per 3 cycles (IDLE→PICK→GNT).
- Reset asserted mid-operation: immediate return to reset values. Any in-flight grant is lost and all locks are dropped.

## Test plan

- Reset, then request: alloc_req_i at cycle 0 → alloc_gnt_o at cycle 2 with alloc_way_o=8'h01 and alloc_evict_o=0. The next cycle shows way_lock_o=8'h01.
- Fill then replace: grant and refill all 8 ways; plru_oldest_i=8'h20; request → alloc_way_o=8'h20, alloc_evict_o=1, way_valid_o bit 5 cleared and bit 5 of way_lock_o set.
- PLRU victim locked: all ways valid, way 3 locked, plru_oldest_i=8'h08 → grant of way 0.
- All ways locked: request held 5 cycles → no grant and stall_cnt_o=5. Refill way 6 → grant way 6 two cycles later.
- Protocol errors:
  - refill_way_i=2 while way 2 is unlocked → err_o=1 stays set and way_valid_o is unchanged;
  - inval of a locked way → ignored, err_o unchanged.
- Simultaneous events: hit way 1, refill way 4 and GNT way 7 in one cycle → plru_access_o=8'h92. Reset asserted during PICK → state IDLE and all outputs at reset values.

Source files
------------

// File: rtl/bank_htu_victim_ctrl.sv
// Victim selection and way valid/lock tracking for one 8-way bank hit-test-unit set.
// Drives the PLRU access vector from hits, accepted refills and grants.
module bank_htu_victim_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        hit_vld_i,
  input  logic [7:0]  hit_way_i,
  input  logic        alloc_req_i,
  output logic        alloc_gnt_o,
  output logic [7:0]  alloc_way_o,
  output logic        alloc_evict_o,
  input  logic        refill_vld_i,
  input  logic [2:0]  refill_way_i,
  input  logic        inval_vld_i,
  input  logic [2:0]  inval_way_i,
  output logic [7:0]  plru_access_o,
  input  logic [7:0]  plru_oldest_i,
  output logic [7:0]  way_valid_o,
  output logic [7:0]  way_lock_o,
  output logic        err_o,
  output logic [15:0] stall_cnt_o
);

  // state | meaning
  // IDLE  | waiting for an allocation request
  // PICK  | choosing a victim; stalls while every way is locked
  // GNT   | one-cycle grant of the registered victim
  typedef enum logic [1:0] {IDLE, PICK, GNT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  lock_q, lock_d;
  logic [7:0]  victim_q, victim_d, victim_c;
  logic        err_q, err_d;
  logic [15:0] stall_q, stall_d;

  logic [7:0]  free_ways, unlocked, oldest_ok;
  logic [7:0]  refill_dec, inval_dec, hit_eff;
  logic        refill_ok, inval_ok, hit_onehot, gnt;

  assign gnt        = (state_q == GNT);
  assign unlocked   = ~lock_q;
  assign free_ways  = ~valid_q & unlocked;
  assign oldest_ok  = plru_oldest_i & unlocked;
  assign refill_dec = 8'd1 << refill_way_i;
  assign inval_dec  = 8'd1 << inval_way_i;
  assign refill_ok  = refill_vld_i & (|(refill_dec & lock_q));
  assign inval_ok   = inval_vld_i & (|(inval_dec & unlocked));
  assign hit_onehot = (hit_way_i != 8'd0) && ((hit_way_i & (hit_way_i - 8'd1)) == 8'd0);
  assign hit_eff    = (hit_vld_i && hit_onehot) ? (hit_way_i & valid_q) : 8'd0;

  // x & -x isolates the lowest set bit; plru_oldest_i is assumed one-hot
  always_comb begin
    victim_c = 8'd0;
    if (|free_ways)
      victim_c = free_ways & (~free_ways + 8'd1);
    else if (|oldest_ok)
      victim_c = oldest_ok;
    else
      victim_c = unlocked & (~unlocked + 8'd1);
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    stall_d  = stall_q;
    case (state_q)
      IDLE: if (alloc_req_i) state_d = PICK;
      PICK: begin
        if (&lock_q) begin
          if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        end else begin
          victim_d = victim_c;
          state_d  = GNT;
        end
      end
      GNT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, then refill, then invalidate: later events win on the same way
  always_comb begin
    lock_d  = lock_q;
    valid_d = valid_q;
    if (gnt) begin
      lock_d  = lock_d | victim_q;
      valid_d = valid_d & ~victim_q;
    end
    if (refill_ok) begin
      lock_d  = lock_d & ~refill_dec;
      valid_d = valid_d | refill_dec;
    end
    if (inval_ok)
      valid_d = valid_d & ~inval_dec;
    err_d = err_q | (refill_vld_i & ~refill_ok) | (hit_vld_i & ~hit_onehot);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      valid_q  <= 8'd0;
      lock_q   <= 8'd0;
      victim_q <= 8'd0;
      err_q    <= 1'b0;
      stall_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      lock_q   <= lock_d;
      victim_q <= victim_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
    end
  end

  assign alloc_gnt_o   = gnt;
  assign alloc_way_o   = gnt ? victim_q : 8'd0;
  assign alloc_evict_o = gnt & (|(victim_q & valid_q));
  assign plru_access_o = hit_eff | (refill_ok ? refill_dec : 8'd0) | alloc_way_o;
  assign way_valid_o   = valid_q;
  assign way_lock_o    = lock_q;
  assign err_o         = err_q;
  assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_bank_htu_victim_ctrl.sv
// Bench for bank_htu_victim_ctrl: per-cycle reference model compare plus directed literal checks.
module tb_bank_htu_victim_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        hit_vld_i = 1'b0;
  logic [7:0]  hit_way_i = 8'd0;
  logic        alloc_req_i = 1'b0;
  logic        alloc_gnt_o;
  logic [7:0]  alloc_way_o;
  logic        alloc_evict_o;
  logic        refill_vld_i = 1'b0;
  logic [2:0]  refill_way_i = 3'd0;
  logic        inval_vld_i = 1'b0;
  logic [2:0]  inval_way_i = 3'd0;
  logic [7:0]  plru_access_o;
  logic [7:0]  plru_oldest_i = 8'd0;
  logic [7:0]  way_valid_o;
  logic [7:0]  way_lock_o;
  logic        err_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  bank_htu_victim_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .hit_vld_i(hit_vld_i), .hit_way_i(hit_way_i),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o),
    .alloc_way_o(alloc_way_o), .alloc_evict_o(alloc_evict_o),
    .refill_vld_i(refill_vld_i), .refill_way_i(refill_way_i),
    .inval_vld_i(inval_vld_i), .inval_way_i(inval_way_i),
    .plru_access_o(plru_access_o), .plru_oldest_i(plru_oldest_i),
    .way_valid_o(way_valid_o), .way_lock_o(way_lock_o),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: request progress as a phase number, ways as bit flags
  bit [7:0] m_valid, m_lock;
  int       m_phase;
  int       m_victim;
  bit       m_err;
  int       m_stall;

  function automatic int oh_idx(input logic [7:0] v);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < 8; i++)
      if (v[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic int pick(input bit [7:0] vl, input bit [7:0] lk, input logic [7:0] oldest);
    int oi;
    for (int i = 0; i < 8; i++)
      if (!vl[i] && !lk[i]) return i;
    oi = oh_idx(oldest);
    if (oi >= 0 && !lk[oi]) return oi;
    for (int i = 0; i < 8; i++)
      if (!lk[i]) return i;
    return -1;
  endfunction

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_valid  <= '0;
      m_lock   <= '0;
      m_phase  <= 0;
      m_victim <= 0;
      m_err    <= 1'b0;
      m_stall  <= 0;
    end else begin
      bit [7:0] nv, nl;
      bit ne;
      int v;
      nv = m_valid;
      nl = m_lock;
      ne = m_err;
      if (m_phase == 2) begin
        nl[m_victim] = 1'b1;
        nv[m_victim] = 1'b0;
      end
      if (refill_vld_i) begin
        if (m_lock[refill_way_i]) begin
          nl[refill_way_i] = 1'b0;
          nv[refill_way_i] = 1'b1;
        end else ne = 1'b1;
      end
      if (inval_vld_i && !m_lock[inval_way_i]) nv[inval_way_i] = 1'b0;
      if (hit_vld_i && oh_idx(hit_way_i) < 0) ne = 1'b1;
      case (m_phase)
        0: if (alloc_req_i) m_phase <= 1;
        1: begin
          v = pick(m_valid, m_lock, plru_oldest_i);
          if (v < 0) m_stall <= (m_stall < 65535) ? m_stall + 1 : 65535;
          else begin m_victim <= v; m_phase <= 2; end
        end
        default: m_phase <= 0;
      endcase
      m_valid <= nv;
      m_lock  <= nl;
      m_err   <= ne;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    logic [7:0] e_way, e_acc;
    int hi;
    e_way = (m_phase == 2) ? (8'd1 << m_victim) : 8'd0;
    e_acc = e_way;
    hi = oh_idx(hit_way_i);
    if (hit_vld_i && hi >= 0 && m_valid[hi]) e_acc[hi] = 1'b1;
    if (refill_vld_i && m_lock[refill_way_i]) e_acc[refill_way_i] = 1'b1;
    cmp("m_gnt", {31'd0, alloc_gnt_o}, {31'd0, m_phase == 2});
    cmp("m_way", {24'd0, alloc_way_o}, {24'd0, e_way});
    cmp("m_evict", {31'd0, alloc_evict_o}, {31'd0, (m_phase == 2) && m_valid[m_victim]});
    cmp("m_access", {24'd0, plru_access_o}, {24'd0, e_acc});
    cmp("m_valid", {24'd0, way_valid_o}, {24'd0, m_valid});
    cmp("m_lock", {24'd0, way_lock_o}, {24'd0, m_lock});
    cmp("m_err", {31'd0, err_o}, {31'd0, m_err});
    cmp("m_stall", {16'd0, stall_cnt_o}, m_stall);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic do_grant(output logic [7:0] way, output logic evict);
    bit seen = 1'b0;
    way = 8'd0;
    evict = 1'b0;
    alloc_req_i = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (alloc_gnt_o) begin
        seen = 1'b1;
        way = alloc_way_o;
        evict = alloc_evict_o;
      end
    end
    alloc_req_i = 1'b0;
    cmp("grant_seen", {31'd0, seen}, 32'd1);
    tick();
  endtask

  task automatic refill(input int w);
    refill_vld_i = 1'b1;
    refill_way_i = 3'(w);
    tick();
    refill_vld_i = 1'b0;
  endtask

  task automatic inval(input int w);
    inval_vld_i = 1'b1;
    inval_way_i = 3'(w);
    tick();
    inval_vld_i = 1'b0;
  endtask

  logic [7:0] gw;
  logic       ge;

  initial begin
    #1 rst_n_i = 1'b0;
    tick();
    tick();
    cmp("rst_valid", {24'd0, way_valid_o}, 32'h00);
    cmp("rst_lock", {24'd0, way_lock_o}, 32'h00);
    cmp("rst_stall", {16'd0, stall_cnt_o}, 32'd0);
    rst_n_i = 1'b1;
    tick();

    // first request: grant two cycles later on way 0
    alloc_req_i = 1'b1;
    tick();
    cmp("t1_pick_nognt", {31'd0, alloc_gnt_o}, 32'd0);
    tick();
    cmp("t1_gnt", {31'd0, alloc_gnt_o}, 32'd1);
    cmp("t1_way", {24'd0, alloc_way_o}, 32'h01);
    cmp("t1_evict", {31'd0, alloc_evict_o}, 32'd0);
    alloc_req_i = 1'b0;
    tick();
    cmp("t1_lock", {24'd0, way_lock_o}, 32'h01);

    // fill all ways, then replace the PLRU-oldest
    refill(0);
    for (int i = 1; i < 8; i++) begin
      do_grant(gw, ge);
      cmp("t2_fill_way", {24'd0, gw}, 32'd1 << i);
      refill(i);
    end
    cmp("t2_all_valid", {24'd0, way_valid_o}, 32'hFF);
    plru_oldest_i = 8'h20;
    do_grant(gw, ge);
    cmp("t2_repl_way", {24'd0, gw}, 32'h20);
    cmp("t2_repl_evict", {31'd0, ge}, 32'd1);
    cmp("t2_valid", {24'd0, way_valid_o}, 32'hDF);
    cmp("t2_lock", {24'd0, way_lock_o}, 32'h20);
    refill(5);

    // PLRU-oldest locked falls back to lowest unlocked way
    plru_oldest_i = 8'h08;
    do_grant(gw, ge);
    cmp("t3_lock_way3", {24'd0, gw}, 32'h08);
    do_grant(gw, ge);
    cmp("t3_fallback", {24'd0, gw}, 32'h01);
    refill(3);
    refill(0);
    plru_oldest_i = 8'h00;

    // all ways locked: stall then release by refill
    do_reset();
    for (int i = 0; i < 8; i++) do_grant(gw, ge);
    cmp("t4_all_locked", {24'd0, way_lock_o}, 32'hFF);
    alloc_req_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp("t4_no_gnt", {31'd0, alloc_gnt_o}, 32'd0);
    end
    cmp("t4_stall5", {16'd0, stall_cnt_o}, 32'd5);
    refill_vld_i = 1'b1;
    refill_way_i = 3'd6;
    tick();
    refill_vld_i = 1'b0;
    cmp("t4_gnt_not_yet", {31'd0, alloc_gnt_o}, 32'd0);
    tick();
    cmp("t4_gnt", {31'd0, alloc_gnt_o}, 32'd1);
    cmp("t4_way6", {24'd0, alloc_way_o}, 32'h40);
    alloc_req_i = 1'b0;
    tick();
    cmp("t4_stall6", {16'd0, stall_cnt_o}, 32'd6);

    // protocol errors
    inval(1);
    cmp("t5_inval_locked_err", {31'd0, err_o}, 32'd0);
    cmp("t5_inval_locked_lock", {24'd0, way_lock_o}, 32'hFF);
    refill(2);
    cmp("t5_refill_ok_valid", {24'd0, way_valid_o}, 32'h04);
    cmp("t5_refill_ok_err", {31'd0, err_o}, 32'd0);
    refill(2);
    cmp("t5_refill_bad_err", {31'd0, err_o}, 32'd1);
    cmp("t5_refill_bad_valid", {24'd0, way_valid_o}, 32'h04);
    tick();
    tick();
    cmp("t5_err_sticky", {31'd0, err_o}, 32'd1);

    // simultaneous hit, refill and grant
    do_reset();
    for (int i = 0; i < 8; i++) do_grant(gw, ge);
    refill(1);
    refill(7);
    inval(7);
    alloc_req_i = 1'b1;
    tick();
    tick();
    hit_vld_i = 1'b1;
    hit_way_i = 8'h02;
    refill_vld_i = 1'b1;
    refill_way_i = 3'd4;
    alloc_req_i = 1'b0;
    #1;
    cmp("t6_gnt_way7", {24'd0, alloc_way_o}, 32'h80);
    cmp("t6_access", {24'd0, plru_access_o}, 32'h92);
    tick();
    hit_vld_i = 1'b0;
    hit_way_i = 8'h00;
    refill_vld_i = 1'b0;
    cmp("t6_lock", {24'd0, way_lock_o}, 32'hED);
    cmp("t6_valid", {24'd0, way_valid_o}, 32'h12);

    // malformed hit, then reset during PICK
    hit_vld_i = 1'b1;
    hit_way_i = 8'h03;
    tick();
    hit_vld_i = 1'b0;
    hit_way_i = 8'h00;
    cmp("t7_bad_hit_err", {31'd0, err_o}, 32'd1);
    alloc_req_i = 1'b1;
    tick();
    rst_n_i = 1'b0;
    #1;
    cmp("t7_rst_gnt", {31'd0, alloc_gnt_o}, 32'd0);
    cmp("t7_rst_valid", {24'd0, way_valid_o}, 32'h00);
    cmp("t7_rst_lock", {24'd0, way_lock_o}, 32'h00);
    cmp("t7_rst_err", {31'd0, err_o}, 32'd0);
    cmp("t7_rst_access", {24'd0, plru_access_o}, 32'h00);
    alloc_req_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();
    do_grant(gw, ge);
    cmp("t7_after_rst_way", {24'd0, gw}, 32'h01);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
